// File: rtl/lsu_rmw.sv
// Load/store unit in front of a word-only data memory: aligns loads and turns byte/half stores into read-modify-write.
// Optional performance counters are compiled in with LSU_PERF_CNT_EN.
module lsu_rmw #(
  parameter logic [31:0] MEM_BASE       = 32'h0000_0000,
  parameter int unsigned MEM_SIZE_BYTES = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_rsp_valid,
  output logic        o_rsp_err,
  output logic [31:0] o_rsp_rdata,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
`ifdef LSU_PERF_CNT_EN
  output logic [31:0] o_cnt_load,
  output logic [31:0] o_cnt_store,
  output logic [31:0] o_cnt_err,
`endif
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_ERR, S_SETUP, S_LOAD, S_ST_W, S_RMW_RD, S_RMW_WR
  } state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  function automatic logic req_bad(input logic we, input logic [2:0] f3, input logic [31:0] a);
    logic        illegal;
    logic        misaligned;
    logic        out_of_range;
    logic [32:0] limit;
    limit        = {1'b0, MEM_BASE} + 33'(MEM_SIZE_BYTES);
    illegal      = we ? (f3 > 3'b010)
                      : !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misaligned   = ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a[1:0] != 2'b00));
    out_of_range = (a < MEM_BASE) || ({1'b0, a} >= limit);
    return illegal || misaligned || out_of_range;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{off, 3'b000} +: 8];
    h = word[{off[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'h0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'h0, h};
      default: r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] old, input logic [31:0] wd);
    logic [31:0] m;
    m = old;
    if (f3[1:0] == 2'b00) m[{off, 3'b000} +: 8] = wd[7:0];
    else                  m[{off[1], 4'b0000} +: 16] = wd[15:0];
    return m;
  endfunction

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (i_req_valid) begin
          we_d     = i_req_we;
          funct3_d = i_funct3;
          addr_d   = i_addr;
          wdata_d  = i_wdata;
          state_d  = req_bad(i_req_we, i_funct3, i_addr) ? S_ERR : S_SETUP;
        end
      end
      S_ERR: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        rsp_rdata_d = 32'h0;
        state_d     = S_IDLE;
      end
      // Address (and full-word store data) are registered here so MEM sees only flop outputs.
      S_SETUP: begin
        mem_addr_d = {addr_q[31:2], 2'b00};
        if (!we_q) begin
          state_d = S_LOAD;
        end else if (funct3_q == 3'b010) begin
          mem_wdata_d = wdata_q;
          state_d     = S_ST_W;
        end else begin
          state_d = S_RMW_RD;
        end
      end
      S_LOAD: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = load_extend(funct3_q, addr_q[1:0], i_mem_rdata);
        state_d     = S_IDLE;
      end
      S_RMW_RD: begin
        mem_wdata_d = merge_lanes(funct3_q, addr_q[1:0], i_mem_rdata, wdata_q);
        state_d     = S_RMW_WR;
      end
      S_ST_W, S_RMW_WR: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = 32'h0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'b000;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 32'h0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign o_req_ready = (state_q == S_IDLE);
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_mem_we    = (state_q == S_ST_W) || (state_q == S_RMW_WR);
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;

`ifdef LSU_PERF_CNT_EN
  logic [31:0] cnt_load_q, cnt_store_q, cnt_err_q;

  // Each counter steps on the same edge that raises the matching response pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_load_q  <= 32'h0;
      cnt_store_q <= 32'h0;
      cnt_err_q   <= 32'h0;
    end else begin
      if (state_q == S_LOAD) cnt_load_q <= cnt_load_q + 32'd1;
      if ((state_q == S_ST_W) || (state_q == S_RMW_WR)) cnt_store_q <= cnt_store_q + 32'd1;
      if (state_q == S_ERR) cnt_err_q <= cnt_err_q + 32'd1;
    end
  end

  assign o_cnt_load  = cnt_load_q;
  assign o_cnt_store = cnt_store_q;
  assign o_cnt_err   = cnt_err_q;
`endif

endmodule

// File: tb/tb_lsu_rmw.sv
// Scoreboard bench for lsu_rmw: directed requests push expected responses, a monitor pops and compares.
module tb_lsu_rmw;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_we = 1'b0;
  logic [2:0]  i_funct3 = 3'b000;
  logic [31:0] i_addr = 32'h0;
  logic [31:0] i_wdata = 32'h0;
  logic        o_rsp_valid;
  logic        o_rsp_err;
  logic [31:0] o_rsp_rdata;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [31:0] i_mem_rdata;
`ifdef LSU_PERF_CNT_EN
  logic [31:0] o_cnt_load, o_cnt_store, o_cnt_err;
`endif

  lsu_rmw #(.MEM_BASE(32'h0), .MEM_SIZE_BYTES(1024)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_we(i_req_we), .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
    .o_rsp_valid(o_rsp_valid), .o_rsp_err(o_rsp_err), .o_rsp_rdata(o_rsp_rdata),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
`ifdef LSU_PERF_CNT_EN
    .o_cnt_load(o_cnt_load), .o_cnt_store(o_cnt_store), .o_cnt_err(o_cnt_err),
`endif
    .i_mem_rdata(i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  // Word memory model with combinational read and a backdoor preload port.
  logic [31:0] mem [0:255];
  logic        bd_we = 1'b0;
  logic [7:0]  bd_idx = 8'h0;
  logic [31:0] bd_data = 32'h0;
  assign i_mem_rdata = mem[o_mem_addr[9:2]];
  always @(posedge i_clk) begin
    if (o_mem_we) mem[o_mem_addr[9:2]] <= o_mem_wdata;
    else if (bd_we) mem[bd_idx] <= bd_data;
  end

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic        err;
    logic [31:0] rdata;
    int          at;
  } exp_t;
  exp_t sb_q[$];

  int n_vec = 0;
  int n_fail = 0;
  int we_count = 0;
  int we_cyc = 0;
  logic [31:0] we_last_data = 32'h0;
  logic [31:0] we_last_addr = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  always @(negedge i_clk) begin
    exp_t e;
    if (o_rsp_valid) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_rsp: got rsp err=%0b rdata=%h at cycle %0d, required none",
                 o_rsp_err, o_rsp_rdata, cyc);
      end else begin
        e = sb_q.pop_front();
        chk({e.name, "_err"}, {31'h0, o_rsp_err}, {31'h0, e.err});
        chk({e.name, "_rdata"}, o_rsp_rdata, e.rdata);
        chk({e.name, "_cycle"}, cyc, e.at);
      end
    end
    if (o_mem_we) begin
      we_count++;
      we_cyc       = cyc;
      we_last_data = o_mem_wdata;
      we_last_addr = o_mem_addr;
    end
  end

  task automatic bd_write(input logic [7:0] idx, input logic [31:0] d);
    @(negedge i_clk);
    bd_we = 1'b1; bd_idx = idx; bd_data = d;
    @(negedge i_clk);
    bd_we = 1'b0;
  endtask

  // Issues one request; n returns the accept edge index. lat is the expected edge offset of the response.
  task automatic issue(input string name, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic e_err, input logic [31:0] e_rd, input int lat,
                       input bit expect_rsp, output int n);
    exp_t e;
    int   t;
    t = 0;
    n = 0;
    @(negedge i_clk);
    while (!o_req_ready && t < 50) begin
      @(negedge i_clk);
      t++;
    end
    if (!o_req_ready) begin
      n_vec++;
      n_fail++;
      $display("FAIL %s_ready: got ready=0 after 50 cycles, required 1", name);
    end else begin
      i_req_valid = 1'b1; i_req_we = we; i_funct3 = f3; i_addr = a; i_wdata = wd;
      @(posedge i_clk);
      #1;
      n = cyc;
      i_req_valid = 1'b0; i_req_we = 1'b0; i_funct3 = 3'b111; i_addr = 32'hFFFF_FFFF; i_wdata = 32'hDEAD_DEAD;
      if (expect_rsp) begin
        e.name = name; e.err = e_err; e.rdata = e_rd; e.at = n + lat;
        sb_q.push_back(e);
      end
    end
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 50) begin
      @(negedge i_clk);
      t++;
    end
    @(negedge i_clk);
    chk({name, "_pending"}, sb_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int we_base;
    repeat (3) @(negedge i_clk);
    chk("rst_ready", {31'h0, o_req_ready}, 32'h1);
    chk("rst_rsp_valid", {31'h0, o_rsp_valid}, 32'h0);
    chk("rst_rsp_err", {31'h0, o_rsp_err}, 32'h0);
    chk("rst_rdata", o_rsp_rdata, 32'h0);
    chk("rst_mem_we", {31'h0, o_mem_we}, 32'h0);
    chk("rst_mem_addr", o_mem_addr, 32'h0);
    chk("rst_mem_wdata", o_mem_wdata, 32'h0);
    i_rst_n = 1'b1;

    bd_write(8'h04, 32'h8899_AABB);
    bd_write(8'h08, 32'hDEAD_BEEF);

    // Loads: alignment and extension.
    issue("lb_13",  1'b0, 3'b000, 32'h13, 32'h0, 1'b0, 32'hFFFF_FF88, 2, 1'b1, n);
    issue("lbu_12", 1'b0, 3'b100, 32'h12, 32'h0, 1'b0, 32'h0000_0099, 2, 1'b1, n);
    issue("lh_10",  1'b0, 3'b001, 32'h10, 32'h0, 1'b0, 32'hFFFF_AABB, 2, 1'b1, n);
    issue("lhu_12", 1'b0, 3'b101, 32'h12, 32'h0, 1'b0, 32'h0000_8899, 2, 1'b1, n);
    issue("lb_10",  1'b0, 3'b000, 32'h10, 32'h0, 1'b0, 32'hFFFF_FFBB, 2, 1'b1, n);
    issue("lw_10",  1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'h8899_AABB, 2, 1'b1, n);
    drain("loads");

    // Halfword read-modify-write.
    we_base = we_count;
    issue("sh_12", 1'b1, 3'b001, 32'h12, 32'h1234_CAFE, 1'b0, 32'h0, 3, 1'b1, n);
    drain("sh");
    chk("sh_we_pulses", we_count - we_base, 1);
    chk("sh_we_data", we_last_data, 32'hCAFE_AABB);
    chk("sh_we_addr", we_last_addr, 32'h10);
    chk("sh_we_cycle", we_cyc, n + 2);
    issue("lw_after_sh", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hCAFE_AABB, 2, 1'b1, n);

    // Byte read-modify-write into lane 1.
    issue("sb_11", 1'b1, 3'b000, 32'h11, 32'hFFFF_FF77, 1'b0, 32'h0, 3, 1'b1, n);
    issue("lw_after_sb", 1'b0, 3'b010, 32'h10, 32'h0, 1'b0, 32'hCAFE_77BB, 2, 1'b1, n);
    drain("sb");

    // Error responses: misaligned, out of range, illegal funct3.
    we_base = we_count;
    issue("lw_11_mis",  1'b0, 3'b010, 32'h11,  32'h0, 1'b1, 32'h0, 1, 1'b1, n);
    issue("sh_03_mis",  1'b1, 3'b001, 32'h03,  32'h5555, 1'b1, 32'h0, 1, 1'b1, n);
    issue("sw_400_oor", 1'b1, 3'b010, 32'h400, 32'h1, 1'b1, 32'h0, 1, 1'b1, n);
    issue("lb_ffff_oor", 1'b0, 3'b000, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'h0, 1, 1'b1, n);
    issue("ld_f3_011",  1'b0, 3'b011, 32'h10,  32'h0, 1'b1, 32'h0, 1, 1'b1, n);
    issue("st_f3_100",  1'b1, 3'b100, 32'h10,  32'h0, 1'b1, 32'h0, 1, 1'b1, n);
    issue("lw_3fc_ok",  1'b0, 3'b010, 32'h3FC, 32'h0, 1'b0, mem[8'hFF], 2, 1'b1, n);
    drain("errors");
    chk("err_no_writes", we_count - we_base, 0);
    chk("err_mem_unchanged", mem[8'h04], 32'hCAFE_77BB);

    // Reset while the byte store is in its read phase.
    we_base = we_count;
    issue("sb_20_abort", 1'b1, 3'b000, 32'h20, 32'h0000_00AA, 1'b0, 32'h0, 3, 1'b0, n);
    @(posedge i_clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("abort_mem_we", {31'h0, o_mem_we}, 32'h0);
    chk("abort_ready", {31'h0, o_req_ready}, 32'h1);
    repeat (3) @(negedge i_clk);
    chk("abort_rsp_valid", {31'h0, o_rsp_valid}, 32'h0);
    i_rst_n = 1'b1;
    repeat (2) @(negedge i_clk);
    chk("abort_no_writes", we_count - we_base, 0);
    chk("abort_mem_unchanged", mem[8'h08], 32'hDEAD_BEEF);

    issue("sw_20", 1'b1, 3'b010, 32'h20, 32'h0000_0055, 1'b0, 32'h0, 2, 1'b1, n);
    issue("lw_20", 1'b0, 3'b010, 32'h20, 32'h0, 1'b0, 32'h0000_0055, 2, 1'b1, n);
    drain("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  end

endmodule
